mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 36 +++
 rtl/mem_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side bus for the load/store unit.
interface mem_lsu_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [2:0]                req_funct3;
  logic [XLEN-1:0]           req_addr;
  logic [XLEN-1:0]           req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [XLEN-1:0]           resp_rdata;
  logic [1:0]                resp_fault;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_WIDTH-OFF-1:0] mem_addr;
  logic [NB-1:0]             mem_be;
  logic [XLEN-1:0]           mem_wdata;
  logic                      mem_ack;
  logic [XLEN-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: maps RISC-V sized accesses onto a word-wide memory port,
// with alignment/range/funct3 checks, load extension and an ack timeout.
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input logic      clk,
  input logic      rstn,
  mem_lsu_if.slave bus
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int MAW = ADDR_WIDTH - OFF;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] F_OK  = 2'd0;
  localparam logic [1:0] F_MIS = 2'd1;
  localparam logic [1:0] F_ILL = 2'd2;
  localparam logic [1:0] F_TO  = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_RESP = 2'd2} state_e;

  function automatic logic [NB-1:0] be_mask(input logic [1:0] size, input logic [OFF-1:0] off);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(8'h01);
      2'd1:    m = NB'(8'h03);
      2'd2:    m = NB'(8'h0F);
      2'd3:    m = NB'(8'hFF);
      default: m = '0;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] wdata_rep(input logic [1:0] size, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    int nbytes;
    nbytes = 32'sd1 << size;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = wd[8*(i & (nbytes - 32'sd1)) +: 8];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [OFF-1:0] off,
                                               input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = rd >> {off, 3'b000};
    case (f3[1:0])
      2'd0: begin
        if (f3[2]) r = XLEN'(sh[7:0]);
        else       r = XLEN'($signed(sh[7:0]));
      end
      2'd1: begin
        if (f3[2]) r = XLEN'(sh[15:0]);
        else       r = XLEN'($signed(sh[15:0]));
      end
      2'd2: begin
        if (f3[2]) r = XLEN'(sh[31:0]);
        else       r = XLEN'($signed(sh[31:0]));
      end
      default: r = sh;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MAW-1:0]    mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_fault_q, resp_fault_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF-1:0]    off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [1:0] size_s;
  logic       legal_s;
  logic       in_range_s;
  logic       misal_s;
  logic [1:0] fault_s;
  logic       accept_s;
  logic       timeout_s;

  assign accept_s  = bus.req_valid && req_ready_q;
  assign timeout_s = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Request decode; the fault priority is the order of the if-chain.
  always_comb begin
    size_s = bus.req_funct3[1:0];
    case ({bus.req_write, bus.req_funct3})
      4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
      4'b1_000, 4'b1_001, 4'b1_010: legal_s = 1'b1;
      4'b0_011, 4'b0_110, 4'b1_011: legal_s = (XLEN == 64);
      default:                      legal_s = 1'b0;
    endcase
    in_range_s = (bus.req_addr[XLEN-1:ADDR_WIDTH] == '0);
    case (size_s)
      2'd1:    misal_s = bus.req_addr[0];
      2'd2:    misal_s = (bus.req_addr[1:0] != 2'b00);
      2'd3:    misal_s = (bus.req_addr[2:0] != 3'b000);
      default: misal_s = 1'b0;
    endcase
    if (!legal_s)        fault_s = F_ILL;
    else if (!in_range_s) fault_s = F_ILL;
    else if (misal_s)    fault_s = F_MIS;
    else                 fault_s = F_OK;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; mem_ack is only looked at in MEM and beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = (fault_s != F_OK) ? S_RESP : S_MEM;
        else          state_d = S_IDLE;
      end
      S_MEM: begin
        if (bus.mem_ack || timeout_s) state_d = S_RESP;
        else                          state_d = S_MEM;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
        else                state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-state logic; every output is registered so it is stable for a full cycle.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_MEM);
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_s && (fault_s == F_OK)) begin
          mem_we_d    = bus.req_write;
          mem_addr_d  = bus.req_addr[ADDR_WIDTH-1:OFF];
          mem_be_d    = be_mask(size_s, bus.req_addr[OFF-1:0]);
          mem_wdata_d = bus.req_write ? wdata_rep(size_s, bus.req_wdata) : '0;
          funct3_d    = bus.req_funct3;
          off_d       = bus.req_addr[OFF-1:0];
        end else if (accept_s) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_fault_d = fault_s;
        end else begin
          resp_valid_d = 1'b0;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          resp_valid_d = 1'b1;
          resp_fault_d = F_OK;
          resp_rdata_d = mem_we_q ? '0 : load_ext(funct3_q, off_q, bus.mem_rdata);
        end else if (timeout_s) begin
          resp_valid_d = 1'b1;
          resp_fault_d = F_TO;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_fault_d = F_OK;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_ready_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 2'd0;
      funct3_q     <= 3'd0;
      off_q        <= '0;
      cnt_q        <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (XLEN=32, ADDR_WIDTH=12, TIMEOUT=15).
module tb_mem_lsu;
  localparam int XLEN = 32;
  localparam int AW   = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();
  mem_lsu #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [31:0] g_rdata, g_mwdata;
  logic [1:0]  g_fault;
  logic [9:0]  g_maddr;
  logic [3:0]  g_mbe;
  logic        g_mwe, g_got, g_unstable, g_hold_bad, g_ready_after;
  int          g_mcyc, g_lat;

  // Issues one request, plays memory (ack after ack_after extra cycles, -1 = never),
  // keeps resp_ready low for hold cycles, then completes the handshake.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_after, input logic [31:0] rd,
                         input int hold, input logic ack_in_hold);
    int cyc;
    int wn;
    g_got = 1'b0; g_mcyc = 0; g_lat = 0; g_unstable = 1'b0; g_hold_bad = 1'b0;
    g_ready_after = 1'b0; g_rdata = 32'h0; g_fault = 2'd0;
    g_maddr = 10'h0; g_mbe = 4'h0; g_mwdata = 32'h0; g_mwe = 1'b0;
    wn = 0;
    while (bus.req_ready !== 1'b1 && wn < 20) begin
      @(posedge clk); #1; wn++;
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); #1; cyc++;
      bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        g_got = 1'b1; g_lat = cyc; g_rdata = bus.resp_rdata; g_fault = bus.resp_fault;
        bus.mem_ack = 1'b0;
        break;
      end
      if (bus.mem_req === 1'b1) begin
        g_mcyc++;
        if (g_mcyc == 1) begin
          g_maddr = bus.mem_addr; g_mbe = bus.mem_be; g_mwdata = bus.mem_wdata; g_mwe = bus.mem_we;
        end else if (bus.mem_addr !== g_maddr || bus.mem_be !== g_mbe ||
                     bus.mem_wdata !== g_mwdata || bus.mem_we !== g_mwe) begin
          g_unstable = 1'b1;
        end
        bus.mem_ack   = (g_mcyc == ack_after + 1);
        bus.mem_rdata = rd;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    if (g_got) begin
      for (int h = 0; h < hold; h++) begin
        bus.mem_ack = ack_in_hold;
        @(posedge clk); #1;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== g_rdata ||
            bus.resp_fault !== g_fault || bus.mem_req !== 1'b0) g_hold_bad = 1'b1;
      end
      bus.mem_ack = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      g_ready_after = (bus.req_ready === 1'b1) && (bus.resp_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
    checks++; if ({bus.resp_valid, bus.mem_req, bus.mem_we} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b expected 000", {bus.resp_valid, bus.mem_req, bus.mem_we}); end
    checks++; if (bus.mem_be !== 4'h0 || bus.mem_addr !== 10'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus: got be=%h addr=%h wdata=%h expected zeros", bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.resp_rdata !== 32'h0 || bus.resp_fault !== 2'd0) begin errors++; $display("FAIL rst_resp: got rdata=%h fault=%0d expected 0/0", bus.resp_rdata, bus.resp_fault); end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_held: got ready=%b mem_req=%b expected 0/0", bus.req_ready, bus.mem_req); end
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_release_noaccept: got mem_req=%b resp_valid=%b expected 0/0", bus.mem_req, bus.resp_valid); end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_lw_basic();
    run_txn(1'b0, 3'b010, 32'h010, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0);
    checks++; if (g_maddr !== 10'h004) begin errors++; $display("FAIL lw_maddr: got %h expected 004", g_maddr); end
    checks++; if (g_mbe !== 4'b1111 || g_mwe !== 1'b0) begin errors++; $display("FAIL lw_be_we: got be=%b we=%b expected 1111/0", g_mbe, g_mwe); end
    checks++; if (g_rdata !== 32'hDEADBEEF || g_fault !== 2'd0) begin errors++; $display("FAIL lw_resp: got %h/%0d expected deadbeef/0", g_rdata, g_fault); end
    checks++; if (g_mcyc !== 3 || g_lat !== 4) begin errors++; $display("FAIL lw_timing: got mem_cycles=%0d lat=%0d expected 3/4", g_mcyc, g_lat); end
    checks++; if (g_unstable !== 1'b0 || g_ready_after !== 1'b1) begin errors++; $display("FAIL lw_stable_ready: got unstable=%b ready=%b expected 0/1", g_unstable, g_ready_after); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [8] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001, 3'b100};
    logic [31:0] ad [8] = '{32'h010, 32'h013, 32'h013, 32'h012, 32'h012, 32'h011, 32'h000, 32'h7FC};
    logic [31:0] rd [8] = '{32'hDEADBEEF, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                            32'h80FF1234, 32'h80FF1234, 32'h1234F00D, 32'h123456FE};
    logic [31:0] ex [8] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                            32'hFFFF80FF, 32'h00000012, 32'hFFFFF00D, 32'h000000FE};
    logic [3:0]  be [8] = '{4'hF, 4'h8, 4'h8, 4'hC, 4'hC, 4'h2, 4'h3, 4'h1};
    logic [9:0]  ma [8] = '{10'h004, 10'h004, 10'h004, 10'h004, 10'h004, 10'h004, 10'h000, 10'h1FF};
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, f3[i], ad[i], 32'h0, 1, rd[i], 0, 1'b0);
      checks++; if (g_rdata !== ex[i]) begin errors++; $display("FAIL load[%0d]_rdata: got %h expected %h", i, g_rdata, ex[i]); end
      checks++; if (g_mbe !== be[i]) begin errors++; $display("FAIL load[%0d]_be: got %b expected %b", i, g_mbe, be[i]); end
      checks++; if (g_maddr !== ma[i]) begin errors++; $display("FAIL load[%0d]_maddr: got %h expected %h", i, g_maddr, ma[i]); end
      checks++; if (g_fault !== 2'd0 || g_got !== 1'b1) begin errors++; $display("FAIL load[%0d]_fault: got fault=%0d got_resp=%b expected 0/1", i, g_fault, g_got); end
    end
  endtask

  task automatic test_stores();
    run_txn(1'b1, 3'b001, 32'h006, 32'h1234ABCD, 0, 32'h77777777, 0, 1'b0);
    checks++; if (g_maddr !== 10'h001 || g_mbe !== 4'b1100) begin errors++; $display("FAIL sh_addr_be: got %h/%b expected 001/1100", g_maddr, g_mbe); end
    checks++; if (g_mwdata !== 32'hABCDABCD || g_mwe !== 1'b1) begin errors++; $display("FAIL sh_wdata_we: got %h/%b expected abcdabcd/1", g_mwdata, g_mwe); end
    checks++; if (g_rdata !== 32'h0 || g_fault !== 2'd0 || g_lat !== 2) begin errors++; $display("FAIL sh_resp: got rdata=%h fault=%0d lat=%0d expected 0/0/2", g_rdata, g_fault, g_lat); end
    run_txn(1'b1, 3'b000, 32'h005, 32'h123456A5, 0, 32'h0, 0, 1'b0);
    checks++; if (g_maddr !== 10'h001 || g_mbe !== 4'b0010 || g_mwdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_bus: got %h/%b/%h expected 001/0010/a5a5a5a5", g_maddr, g_mbe, g_mwdata); end
    run_txn(1'b1, 3'b010, 32'hFFC, 32'h11223344, 3, 32'h0, 0, 1'b0);
    checks++; if (g_maddr !== 10'h3FF || g_mbe !== 4'hF || g_mwdata !== 32'h11223344) begin errors++; $display("FAIL sw_bus: got %h/%b/%h expected 3ff/1111/11223344", g_maddr, g_mbe, g_mwdata); end
    checks++; if (g_mcyc !== 4 || g_unstable !== 1'b0) begin errors++; $display("FAIL sw_stable: got mem_cycles=%0d unstable=%b expected 4/0", g_mcyc, g_unstable); end
  endtask

  task automatic test_faults();
    logic        wr [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [11] = '{3'b010, 3'b111, 3'b010, 3'b011, 3'b011, 3'b110, 3'b100, 3'b111, 3'b001, 3'b001, 3'b101};
    logic [31:0] ad [11] = '{32'h002, 32'h000, 32'h1000, 32'h000, 32'h000, 32'h000, 32'h000, 32'h1001, 32'h1001, 32'h003, 32'h001};
    logic [1:0]  ef [11] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
    for (int i = 0; i < 11; i++) begin
      run_txn(wr[i], f3[i], ad[i], 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 1'b0);
      checks++; if (g_fault !== ef[i] || g_got !== 1'b1) begin errors++; $display("FAIL fault[%0d]_code: got %0d (resp=%b) expected %0d", i, g_fault, g_got, ef[i]); end
      checks++; if (g_mcyc !== 0 || g_rdata !== 32'h0 || g_lat !== 1) begin errors++; $display("FAIL fault[%0d]_path: got mem_cycles=%0d rdata=%h lat=%0d expected 0/0/1", i, g_mcyc, g_rdata, g_lat); end
    end
  endtask

  task automatic test_timeout();
    int bad;
    run_txn(1'b0, 3'b010, 32'h040, 32'h0, -1, 32'h55555555, 3, 1'b1);
    checks++; if (g_fault !== 2'd3 || g_mcyc !== 15 || g_rdata !== 32'h0) begin errors++; $display("FAIL timeout: got fault=%0d mem_cycles=%0d rdata=%h expected 3/15/0", g_fault, g_mcyc, g_rdata); end
    checks++; if (g_hold_bad !== 1'b0 || g_ready_after !== 1'b1) begin errors++; $display("FAIL timeout_late_ack: got hold_bad=%b ready=%b expected 0/1", g_hold_bad, g_ready_after); end
    bad = 0;
    bus.mem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0) bad++;
    end
    bus.mem_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_ack_ignored: got %0d bad cycles expected 0", bad); end
    run_txn(1'b0, 3'b010, 32'h044, 32'h0, 14, 32'hCAFEF00D, 0, 1'b0);
    checks++; if (g_fault !== 2'd0 || g_mcyc !== 15 || g_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ack_last_cycle: got fault=%0d mem_cycles=%0d rdata=%h expected 0/15/cafef00d", g_fault, g_mcyc, g_rdata); end
  endtask

  task automatic test_resp_hold();
    run_txn(1'b0, 3'b010, 32'h010, 32'h0, 0, 32'h0BADF00D, 5, 1'b0);
    checks++; if (g_rdata !== 32'h0BADF00D || g_lat !== 2) begin errors++; $display("FAIL hold_resp: got rdata=%h lat=%0d expected 0badf00d/2", g_rdata, g_lat); end
    checks++; if (g_hold_bad !== 1'b0 || g_ready_after !== 1'b1) begin errors++; $display("FAIL hold_stable: got hold_bad=%b ready=%b expected 0/1", g_hold_bad, g_ready_after); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 3'b000, 32'h021, 32'h000000AB, 0, 32'h0, 0, 1'b0);
    checks++; if (g_mbe !== 4'b0010 || g_mwdata !== 32'hABABABAB) begin errors++; $display("FAIL b2b_store: got %b/%h expected 0010/abababab", g_mbe, g_mwdata); end
    run_txn(1'b0, 3'b100, 32'h021, 32'h0, 0, 32'h0000AB00, 0, 1'b0);
    checks++; if (g_rdata !== 32'h000000AB || g_lat !== 2) begin errors++; $display("FAIL b2b_load: got %h lat=%0d expected 000000ab/2", g_rdata, g_lat); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h020;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req_up: got %b expected 1", bus.mem_req); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got mem_req=%b ready=%b expected 0/0", bus.mem_req, bus.req_ready); end
    @(posedge clk); #3 rstn = 1'b1;
    bad = 0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 2) bus.mem_ack = 1'b0;
      if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_no_resp: got %0d bad cycles ready=%b expected 0/1", bad, bus.req_ready); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_lw_basic();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
